// File: rtl/core_pkg.sv
// Shared core types and constants.
// Used by fetch, IF/ID and control decode.
package core_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } if_id_t;

    function automatic logic [31:0] word_align(
        input logic [31:0] a
    );
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid.
// The skid absorbs a response that lands while decode stalls.
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   load_id,
    input  logic   load_sk,
    input  logic   shift,
    input  logic   drain,
    input  if_id_t din,
    output logic   id_valid,
    output if_id_t id_q,
    output logic   sk_valid
);

    if_id_t sk_q;

    // IF/ID: flush wins, then fresh data, then skid, then drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_q     <= '{instr: NOP_INSTR, pc4: '0};
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load_id) begin
            id_valid <= 1'b1;
            id_q     <= din;
        end else if (shift) begin
            id_valid <= sk_valid;
            id_q     <= sk_q;
        end else if (drain) begin
            id_valid <= 1'b0;
        end
    end

    // Skid entry: filled on a stalled response, emptied by shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_valid <= 1'b0;
            sk_q     <= '{instr: NOP_INSTR, pc4: '0};
        end else if (flush) begin
            sk_valid <= 1'b0;
        end else if (load_sk) begin
            sk_valid <= 1'b1;
            sk_q     <= din;
        end else if (shift) begin
            sk_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem port,
// redirect handling with stale-response discard.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc4,
    output logic [OP_W-1:0]    id_op,
    output logic [5:0]         id_funct
);

    fetch_state_t state;

    logic [31:0] pc;
    logic [31:0] fetch_addr;
    logic [31:0] addr4;
    logic [31:0] tgt;
    logic        rsp;
    logic        free;
    logic        flush;
    logic        ld_id;
    logic        ld_sk;
    logic        shift;
    logic        drain;
    logic        sk_valid;
    if_id_t      din;
    if_id_t      id_q;

    assign imem_addr = fetch_addr;
    assign addr4     = fetch_addr + 32'd4;
    assign tgt       = word_align(redirect_pc);
    assign rsp       = (state == REQ) && imem_valid;
    assign free      = !id_valid || !stall;
    assign din       = '{instr: imem_rdata, pc4: addr4};

    assign id_instr  = id_q.instr;
    assign id_pc4    = id_q.pc4;
    assign id_op     = id_q.instr[31:26];
    assign id_funct  = id_q.instr[5:0];

    // IF/ID control: redirect suppresses every load/shift
    always_comb begin
        flush = redirect;
        ld_id = 1'b0;
        ld_sk = 1'b0;
        shift = 1'b0;
        drain = 1'b0;
        if (!redirect) begin
            ld_id = rsp && free;
            ld_sk = rsp && !free;
            shift = (state == HOLD) && sk_valid && !stall;
            drain = id_valid && !stall;
        end
    end

    // Fetch FSM with registered request, address and PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= word_align(RESET_PC);
            fetch_addr <= word_align(RESET_PC);
            imem_req   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc         <= tgt;
                        fetch_addr <= tgt;
                    end else begin
                        fetch_addr <= pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        pc <= tgt;
                        if (imem_valid) begin
                            fetch_addr <= tgt;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_valid) begin
                        pc <= addr4;
                        if (free) begin
                            fetch_addr <= addr4;
                        end else begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                    if (redirect) begin
                        pc         <= tgt;
                        fetch_addr <= tgt;
                    end else if (!stall) begin
                        fetch_addr <= pc;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc <= tgt;
                    end
                    if (imem_valid) begin
                        state      <= REQ;
                        fetch_addr <= redirect ? tgt : pc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load_id  (ld_id),
        .load_sk  (ld_sk),
        .shift    (shift),
        .drain    (drain),
        .din      (din),
        .id_valid (id_valid),
        .id_q     (id_q),
        .sk_valid (sk_valid)
    );

endmodule
